// File: rtl/ats_eligibility_scheduler.sv
// Per-stream ATS token-bucket eligibility-time calculator.
// Four-state sequencer: latch request, multiply, compare/update, respond.
module ats_eligibility_scheduler #(
   parameter int TIMESTAMP_WIDTH = 72,
   parameter int LENGTH_WIDTH    = 16,
   parameter int RATE_WIDTH      = 24,
   parameter int RATE_FRAC_BITS  = 8,
   parameter int BURST_WIDTH     = 24,
   parameter int NUM_SCHEDULERS  = 8,
   parameter int NUM_GROUPS      = 4,
   localparam int SW = $clog2(NUM_SCHEDULERS),
   localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       cfg_wr_en,
   input  logic [SW-1:0]              cfg_sched_id,
   input  logic [RATE_WIDTH-1:0]      cfg_ticks_per_byte,
   input  logic [BURST_WIDTH-1:0]     cfg_cbs,
   input  logic [TIMESTAMP_WIDTH-1:0] cfg_max_residence,
   input  logic                       s_req_valid,
   output logic                       s_req_ready,
   input  logic [SW-1:0]              s_req_sched_id,
   input  logic [GW-1:0]              s_req_group_id,
   input  logic [LENGTH_WIDTH-1:0]    s_req_length,
   input  logic [TIMESTAMP_WIDTH-1:0] s_req_arrival,
   output logic                       m_res_valid,
   input  logic                       m_res_ready,
   output logic [TIMESTAMP_WIDTH-1:0] m_res_eligibility,
   output logic                       m_res_discard
);
   localparam int TW = TIMESTAMP_WIDTH;
   localparam int LPW = LENGTH_WIDTH + RATE_WIDTH;
   localparam int CPW = BURST_WIDTH + RATE_WIDTH;

   typedef enum logic [1:0] {IDLE, MUL, CMP, RESP} state_t;
   state_t state;
   logic   ready_q;

   logic [RATE_WIDTH-1:0]  tpb_q     [NUM_SCHEDULERS];
   logic [BURST_WIDTH-1:0] cbs_q     [NUM_SCHEDULERS];
   logic [TW-1:0]          maxres_q  [NUM_SCHEDULERS];
   logic [TW-1:0]          bempty_q  [NUM_SCHEDULERS];
   logic [TW-1:0]          gelig_q   [NUM_GROUPS];

   logic [SW-1:0]           r_sid;
   logic [GW-1:0]           r_gid;
   logic                    r_bad;
   logic [LENGTH_WIDTH-1:0] r_len;
   logic [TW-1:0]           r_arr;
   logic [RATE_WIDTH-1:0]   r_tpb;
   logic [BURST_WIDTH-1:0]  r_cbs;
   logic [TW-1:0]           r_maxres;
   logic [TW-1:0]           r_bempty;
   logic [TW-1:0]           r_gelig;
   logic [TW-1:0]           r_sched;
   logic [TW-1:0]           r_full;

   logic           req_bad;
   logic [LPW-1:0] len_prod;
   logic [CPW-1:0] cbs_prod;
   logic [TW-1:0]  len_rec;
   logic [TW-1:0]  e2f;
   logic [TW-1:0]  elig_c;
   logic [TW-1:0]  limit_c;
   logic           disc_c;
   logic [TW-1:0]  bnew_c;

   assign s_req_ready = ready_q;
   assign req_bad = (32'(s_req_sched_id) >= NUM_SCHEDULERS) ||
                    (32'(s_req_group_id) >= NUM_GROUPS);

   always_comb begin
      len_prod = LPW'(r_len) * LPW'(r_tpb);
      cbs_prod = CPW'(r_cbs) * CPW'(r_tpb);
      len_rec  = TW'(len_prod >> RATE_FRAC_BITS);
      e2f      = TW'(cbs_prod >> RATE_FRAC_BITS);
      elig_c   = r_arr;
      if (r_gelig > elig_c) elig_c = r_gelig;
      if (r_sched > elig_c) elig_c = r_sched;
      limit_c  = r_arr + r_maxres;
      disc_c   = r_bad || (elig_c > limit_c);
      // Late frames push the empty point forward by the overshoot
      bnew_c   = (elig_c < r_full) ? r_sched : r_sched + elig_c - r_full;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state             <= IDLE;
         ready_q           <= 1'b0;
         m_res_valid       <= 1'b0;
         m_res_eligibility <= '0;
         m_res_discard     <= 1'b0;
         r_sid    <= '0;
         r_gid    <= '0;
         r_bad    <= 1'b0;
         r_len    <= '0;
         r_arr    <= '0;
         r_tpb    <= '0;
         r_cbs    <= '0;
         r_maxres <= '0;
         r_bempty <= '0;
         r_gelig  <= '0;
         r_sched  <= '0;
         r_full   <= '0;
         for (int i = 0; i < NUM_SCHEDULERS; i++) begin
            tpb_q[i]    <= '0;
            cbs_q[i]    <= '0;
            maxres_q[i] <= '0;
            bempty_q[i] <= '0;
         end
         for (int i = 0; i < NUM_GROUPS; i++) gelig_q[i] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ready_q && s_req_valid) begin
                  r_sid    <= s_req_sched_id;
                  r_gid    <= s_req_group_id;
                  r_bad    <= req_bad;
                  r_len    <= s_req_length;
                  r_arr    <= s_req_arrival;
                  r_tpb    <= tpb_q[s_req_sched_id];
                  r_cbs    <= cbs_q[s_req_sched_id];
                  r_maxres <= maxres_q[s_req_sched_id];
                  r_bempty <= bempty_q[s_req_sched_id];
                  r_gelig  <= gelig_q[s_req_group_id];
                  ready_q  <= 1'b0;
                  state    <= MUL;
               end else begin
                  ready_q  <= 1'b1;
               end
            end
            MUL: begin
               r_sched <= r_bempty + len_rec;
               r_full  <= r_bempty + e2f;
               state   <= CMP;
            end
            CMP: begin
               m_res_valid       <= 1'b1;
               m_res_eligibility <= r_bad ? r_arr : elig_c;
               m_res_discard     <= disc_c;
               if (!disc_c) begin
                  gelig_q[r_gid]  <= elig_c;
                  bempty_q[r_sid] <= bnew_c;
               end
               state <= RESP;
            end
            RESP: begin
               if (m_res_ready) begin
                  m_res_valid <= 1'b0;
                  ready_q     <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // Placed last so a same-edge bucket clear beats the CMP update
         if (cfg_wr_en && (32'(cfg_sched_id) < NUM_SCHEDULERS)) begin
            tpb_q[cfg_sched_id]    <= cfg_ticks_per_byte;
            cbs_q[cfg_sched_id]    <= cfg_cbs;
            maxres_q[cfg_sched_id] <= cfg_max_residence;
            bempty_q[cfg_sched_id] <= '0;
         end
      end
   end
endmodule
